// File: rtl/rv32_wb_ctrl_unit.sv
// Writeback-stage controller: registers the WB mux select and rd, sequences loads,
// drives the RF write port and counts retirements. Optional macro: LOAD_TIMEOUT_EN.
//
//  state   | meaning
//  IDLE    | no instruction pending writeback
//  WB      | accepted non-load writes back this cycle
//  LD_WAIT | load accepted, stalling until dmem_rvalid_in
//  ERR     | load timed out; one-cycle error pulse (LOAD_TIMEOUT_EN only)
module rv32_wb_ctrl_unit #(
    parameter int LD_TIMEOUT = 16,
    parameter int CNT_W      = 32
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             issue_valid_in,
    output logic             issue_ready_out,
    input  logic [2:0]       wb_sel_in,
    input  logic [4:0]       rd_addr_in,
    input  logic             rf_we_in,
    input  logic             is_load_in,
    input  logic             flush_in,
    input  logic             dmem_rvalid_in,
    output logic [2:0]       wb_mux_sel_reg_out,
    output logic             rf_wr_en_out,
    output logic [4:0]       rf_rd_addr_out,
    output logic             stall_out,
    output logic             ld_err_out,
    output logic [CNT_W-1:0] retired_cnt_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        WB      = 2'b01,
        LD_WAIT = 2'b10,
        ERR     = 2'b11
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       sel_reg;
    logic [4:0]       rd_reg;
    logic             we_reg;
    logic             kill_reg, kill_nxt;
    logic             accept;
    logic             wr_ok;
    logic             tmo_hit;
    logic [CNT_W-1:0] retired_cnt;

    assign issue_ready_out    = (state == IDLE) || (state == WB) ||
                                ((state == LD_WAIT) && dmem_rvalid_in);
    assign accept             = issue_valid_in & issue_ready_out & ~flush_in;
    assign wr_ok              = we_reg & (rd_reg != 5'd0);
    assign wb_mux_sel_reg_out = sel_reg;
    assign rf_rd_addr_out     = rd_reg;
    assign retired_cnt_out    = retired_cnt;

`ifdef LOAD_TIMEOUT_EN
    localparam int TMO_W = (LD_TIMEOUT > 2) ? $clog2(LD_TIMEOUT) : 1;
    logic [TMO_W-1:0] tmo_cnt;

    // Every load enters LD_WAIT through an accept, so clearing on accept covers entry.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if ((state == LD_WAIT) && !dmem_rvalid_in) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(LD_TIMEOUT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = (LD_TIMEOUT != 0);
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        kill_nxt     = kill_reg;
        rf_wr_en_out = 1'b0;
        stall_out    = 1'b0;
        ld_err_out   = 1'b0;
        case (state)
            IDLE, WB: begin
                if (state == WB) rf_wr_en_out = wr_ok & ~flush_in;
                state_nxt = IDLE;
                if (accept) state_nxt = is_load_in ? LD_WAIT : WB;
            end
            LD_WAIT: begin
                if (dmem_rvalid_in) begin
                    rf_wr_en_out = wr_ok & ~kill_reg & ~flush_in;
                    kill_nxt     = 1'b0;
                    state_nxt    = IDLE;
                    if (accept) state_nxt = is_load_in ? LD_WAIT : WB;
                end else begin
                    stall_out = 1'b1;
                    if (flush_in) kill_nxt = 1'b1;
                    if (tmo_hit) begin
                        state_nxt = ERR;
                        kill_nxt  = 1'b0;
                    end
                end
            end
            ERR: begin
                stall_out  = 1'b1;
                ld_err_out = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            kill_reg    <= 1'b0;
            sel_reg     <= 3'b000;
            rd_reg      <= 5'd0;
            we_reg      <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state    <= state_nxt;
            kill_reg <= kill_nxt;
            if (accept) begin
                sel_reg <= is_load_in ? 3'b001 : wb_sel_in;
                rd_reg  <= rd_addr_in;
                we_reg  <= rf_we_in;
            end
            if (rf_wr_en_out) retired_cnt <= retired_cnt + 1'b1;
        end
    end

endmodule
